// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } seq_gen_state_t;

    localparam int unsigned SEQ_GEN_PAT_W = 8;
    localparam int unsigned SEQ_GEN_REP_W = 4;
    localparam int unsigned SEQ_GEN_GAP_W = 4;

endpackage

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first,
// repeated with optional idle gaps, on registered out/out_valid.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned PAT_W = SEQ_GEN_PAT_W,
    parameter int unsigned REP_W = SEQ_GEN_REP_W,
    parameter int unsigned GAP_W = SEQ_GEN_GAP_W,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic             err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    seq_gen_state_t   state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_left_q, rep_left_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             len_ok;

    assign len_ok = (len != '0) && (len <= LEN_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            bit_idx_q   <= '0;
            rep_left_q  <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            bit_idx_q   <= bit_idx_d;
            rep_left_q  <= rep_left_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    pat_d      = pattern;
                    len_d      = len;
                    rep_left_d = repeats;
                    gap_d      = gap;
                    bit_idx_d  = len - LEN_W'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - LEN_W'(1);
                end else if (rep_left_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rep_left_d = rep_left_q - REP_W'(1);
                    if (gap_q != '0) begin
                        gap_cnt_d = gap_q;
                        state_d   = GAP;
                    end else begin
                        bit_idx_d = len_q - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                // gap_cnt counts down to 1 so GAP lasts exactly gap_q cycles
                if (gap_cnt_q > GAP_W'(1)) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    gap_cnt_d = '0;
                    bit_idx_d = len_q - LEN_W'(1);
                    state_d   = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the bit appears right after the accept edge.
    always_comb begin
        ready_d     = (state_d == IDLE);
        out_valid_d = (state_d == SHIFT);
        out_d       = out_valid_d && |(pat_d & (PAT_W'(1) << bit_idx_d));
        done_d      = (state_q == SHIFT) && (bit_idx_q == '0) && (rep_left_q == '0);
        err_d       = (state_q == IDLE) && start && !len_ok;
    end

    assign ready     = ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed self-checking bench for sequence_generator.
module tb_sequence_generator;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeats;
    logic [3:0] gap;
    logic       ready;
    logic       out;
    logic       out_valid;
    logic       done;
    logic       err;

    int n_checks;
    int n_errors;

    logic [1:0] run_q;
    logic       det;

    sequence_generator #(
        .PAT_W(8),
        .REP_W(4),
        .GAP_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeats  (repeats),
        .gap      (gap),
        .ready    (ready),
        .out      (out),
        .out_valid(out_valid),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore 111 detector fed by the serial link
    always @(posedge clk or posedge reset) begin
        if (reset) run_q <= 2'd0;
        else if (out_valid && out) run_q <= (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
        else run_q <= 2'd0;
    end
    assign det = (run_q == 2'd3);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status();
        return 32'({err, ready, done, out_valid, out});
    endfunction

    task automatic start_job(input logic [7:0] p, input logic [3:0] l,
                             input logic [3:0] r, input logic [3:0] g);
        @(negedge clk);
        start = 1'b1; pattern = p; len = l; repeats = r; gap = g;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = ~p;
        len     = 4'd0;
        repeats = ~r;
        gap     = ~g;
    endtask

    // Checks n cycles starting 1ns after the accept edge; optional busy start poke.
    task automatic expect_stream(input string tag, input int n, input logic [15:0] ov,
                                 input logic [15:0] vv, input int poke);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke >= 0 && k == poke) begin
                start = 1'b1; len = 4'd3; pattern = 8'h00; repeats = 4'd0; gap = 4'd0;
            end
            if (poke >= 0 && k == poke + 1) start = 1'b0;
            chk(tag, status(), 32'({1'b0, 1'b0, 1'b0, vv[n-1-k], ov[n-1-k]}));
        end
    endtask

    task automatic expect_done(input string tag);
        @(posedge clk);
        #1;
        chk(tag, status(), 32'b01100);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0; repeats = '0; gap = '0;
        #12;
        chk("reset_hold", status(), 32'b01000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_idle", status(), 32'b01000);

        // 1: 111 once, drives the detector
        start_job(8'b0000_0111, 4'd3, 4'd0, 4'd0);
        expect_stream("t1_bits", 3, 16'b111, 16'b111, -1);
        expect_done("t1_done");
        chk("t1_det", 32'(det), 32'd1);
        @(posedge clk);
        #1;
        chk("t1_after", status(), 32'b01000);

        // 2: full-width pattern, busy start poke ignored
        start_job(8'b1011_0010, 4'd8, 4'd0, 4'd0);
        expect_stream("t2_bits", 8, 16'b1011_0010, 16'hFF, 3);
        expect_done("t2_done");

        // 3: repeats with gaps, upper pattern bits ignored
        start_job(8'b1111_1110, 4'd2, 4'd2, 4'd3);
        expect_stream("t3_bits", 12, 16'b1000_0100_0010, 16'b1100_0110_0011, -1);
        expect_done("t3_done");

        // 4: back-to-back repeats, then a new job started in the done cycle
        start_job(8'b0000_0101, 4'd3, 4'd1, 4'd0);
        expect_stream("t4_bits", 6, 16'b101101, 16'b111111, -1);
        start = 1'b1; pattern = 8'h02; len = 4'd2; repeats = 4'd0; gap = 4'd0;
        expect_done("t4_done");
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_stream("t4b_bits", 2, 16'b10, 16'b11, -1);
        expect_done("t4b_done");

        // 5: illegal lengths
        start_job(8'hFF, 4'd0, 4'd0, 4'd0);
        chk("t5_len0_err", status(), 32'b11000);
        @(posedge clk);
        #1;
        chk("t5_len0_clr", status(), 32'b01000);
        start_job(8'hFF, 4'd9, 4'd0, 4'd0);
        chk("t5_len9_err", status(), 32'b11000);
        @(posedge clk);
        #1;
        chk("t5_len9_clr", status(), 32'b01000);

        // 6: asynchronous reset mid-SHIFT
        start_job(8'b1011_0010, 4'd8, 4'd0, 4'd0);
        expect_stream("t6_bits", 4, 16'b1011, 16'b1111, -1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async", status(), 32'b01000);
        #20;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle", status(), 32'b01000);
        start_job(8'b0000_0111, 4'd3, 4'd0, 4'd0);
        expect_stream("t6_rerun", 3, 16'b111, 16'b111, -1);
        expect_done("t6_done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
